// File: rtl/rv32i_types.sv
// Shared RV32I / RVFI monitor types: commit packet layout, word and order types.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [63:0] rvfi_order_t;

  typedef struct packed {
    logic       commit;
    rv32i_word  inst;
    logic       trap;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    rv32i_word  rs1_rdata;
    rv32i_word  rs2_rdata;
    logic [4:0] rd_addr;
    rv32i_word  rd_wdata;
    rv32i_word  pc_rdata;
    rv32i_word  pc_wdata;
    rv32i_word  mem_addr;
    logic [3:0] mem_rmask;
    logic [3:0] mem_wmask;
    rv32i_word  mem_rdata;
    rv32i_word  mem_wdata;
  } RVFIMonPacket;

  localparam int unsigned RVFI_PKT_W   = $bits(RVFIMonPacket);
  localparam int unsigned RVFI_ORDER_W = $bits(rvfi_order_t);

endpackage

// File: rtl/rvfi_fifo.sv
// Valid/ready FIFO with registered storage; a full FIFO still accepts when the
// head is popped in the same cycle. No combinational input-to-output bypass.
module rvfi_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  // A full FIFO always has a valid head, so out_ready alone means a pop frees a slot.
  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CNT_W'(DEPTH)) || out_ready;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + PTR_W'(1);
    if (pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= in_data;
  end

endmodule

// File: rtl/rvfi_commit_queue.sv
// RVFI commit queue: buffers committed packets, tags each with a retirement order.
// Optional PC-continuity checker enabled by defining RVFI_PC_CHECK_EN.
module rvfi_commit_queue
  import rv32i_types::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  RVFIMonPacket in_pkt,
  output logic         in_ready,
  output logic         out_valid,
  output RVFIMonPacket out_pkt,
  output logic [63:0]  out_order,
  input  logic         out_ready,
  output logic         pc_err
);

  localparam int unsigned ENTRY_W = RVFI_ORDER_W + RVFI_PKT_W;

  rvfi_order_t        order_q, order_d;
  logic               push;
  logic [ENTRY_W-1:0] fifo_out;

  assign push = in_pkt.commit && in_ready;

  always_comb begin
    order_d = order_q;
    if (push) order_d = order_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) order_q <= '0;
    else        order_q <= order_d;
  end

  rvfi_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_pkt.commit),
    .in_data   ({order_q, in_pkt}),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (fifo_out),
    .out_ready (out_ready)
  );

  assign out_order = fifo_out[ENTRY_W-1 -: RVFI_ORDER_W];
  assign out_pkt   = RVFIMonPacket'(fifo_out[RVFI_PKT_W-1:0]);

`ifdef RVFI_PC_CHECK_EN
  rv32i_word last_pc_q, last_pc_d;
  logic      have_last_q, have_last_d;
  logic      pc_err_q, pc_err_d;

  // Each pushed packet must start where the previous one said the next PC would be.
  always_comb begin
    last_pc_d   = last_pc_q;
    have_last_d = have_last_q;
    pc_err_d    = pc_err_q;
    if (push) begin
      if (have_last_q && (in_pkt.pc_rdata != last_pc_q)) pc_err_d = 1'b1;
      last_pc_d   = in_pkt.pc_wdata;
      have_last_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_pc_q   <= '0;
      have_last_q <= 1'b0;
      pc_err_q    <= 1'b0;
    end else begin
      last_pc_q   <= last_pc_d;
      have_last_q <= have_last_d;
      pc_err_q    <= pc_err_d;
    end
  end

  assign pc_err = pc_err_q;
`else
  assign pc_err = 1'b0;
`endif

endmodule

// File: tb/tb_rvfi_commit_queue.sv
// Self-checking bench for rvfi_commit_queue against a queue-based reference model.
module tb_rvfi_commit_queue;
  import rv32i_types::*;

  localparam int unsigned DEPTH = 4;
`ifdef RVFI_PC_CHECK_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  typedef logic [RVFI_ORDER_W+RVFI_PKT_W-1:0] entry_t;

  logic         clk;
  logic         rst_n;
  RVFIMonPacket in_pkt;
  logic         in_ready;
  logic         out_valid;
  RVFIMonPacket out_pkt;
  logic [63:0]  out_order;
  logic         out_ready;
  logic         pc_err;

  rvfi_commit_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_pkt    (in_pkt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .out_order (out_order),
    .out_ready (out_ready),
    .pc_err    (pc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  entry_t      mq[$];
  logic [63:0] m_order;
  logic        m_pc_err;
  logic        m_have_last;
  logic [31:0] m_last_pc;
  logic [63:0] got[$];

  function automatic RVFIMonPacket rand_pkt(input logic c);
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    rand_pkt = RVFIMonPacket'(r[312:0]);
    rand_pkt.commit = c;
  endfunction

  function automatic logic exp_ready();
    return (mq.size() < DEPTH) || (mq.size() == DEPTH && out_ready);
  endfunction

  function automatic entry_t exp_head();
    return (mq.size() != 0) ? mq[0] : '0;
  endfunction

  task automatic model_reset();
    mq.delete();
    got.delete();
    m_order     = '0;
    m_pc_err    = 1'b0;
    m_have_last = 1'b0;
    m_last_pc   = '0;
  endtask

  // Apply the queue rules for the inputs currently driven, then advance one clock.
  task automatic step();
    logic rdy;
    logic do_pop;
    rdy    = exp_ready();
    do_pop = (mq.size() != 0) && out_ready;
    if (do_pop) void'(mq.pop_front());
    if (in_pkt.commit && rdy) begin
      mq.push_back({m_order, in_pkt});
      m_order = m_order + 64'd1;
      if (PC_EN) begin
        if (m_have_last && in_pkt.pc_rdata != m_last_pc) m_pc_err = 1'b1;
        m_last_pc   = in_pkt.pc_wdata;
        m_have_last = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_pkt    = rand_pkt(1'b0);
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_pkt    = rand_pkt(1'b1);
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || pc_err !== 1'b0) $display("FAIL reset_hold: out_valid=%b pc_err=%b want 0 0", out_valid, pc_err);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    in_pkt = rand_pkt(1'b0);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || pc_err !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b pc_err=%b want 1 0 0", in_ready, out_valid, pc_err);
    else n_pass++;
    step();
  endtask

  task automatic test_basic();
    logic [31:0] pcs [3];
    pcs = '{32'h60, 32'h64, 32'h68};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_pkt = rand_pkt(i < 3);
      if (i < 3) begin
        in_pkt.pc_rdata = pcs[i];
        in_pkt.pc_wdata = pcs[i] + 32'd4;
      end
      @(negedge clk);
      n_checks++;
      if (in_ready !== exp_ready()) $display("FAIL basic_in_ready: got %b want %b", in_ready, exp_ready());
      else n_pass++;
      n_checks++;
      if (out_valid !== (mq.size() != 0) || (mq.size() != 0 && {out_order, out_pkt} !== exp_head()))
        $display("FAIL basic_head: valid=%b order=%0d want valid=%b order=%0d", out_valid, out_order, mq.size() != 0, exp_head() >> RVFI_PKT_W);
      else n_pass++;
      if (out_valid && out_ready) got.push_back(out_order);
      step();
    end
    n_checks++;
    if (got.size() != 3 || got[0] !== 64'd0 || got[1] !== 64'd1 || got[2] !== 64'd2)
      $display("FAIL basic_orders: got %0d pops want orders 0,1,2", got.size());
    else n_pass++;
    n_checks++;
    if (pc_err !== 1'b0) $display("FAIL basic_pc_err: got %b want 0", pc_err);
    else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_pkt    = rand_pkt(i < 5);
      out_ready = (i >= 5);
      @(negedge clk);
      n_checks++;
      if (in_ready !== exp_ready() || out_valid !== (mq.size() != 0) || (mq.size() != 0 && {out_order, out_pkt} !== exp_head()))
        $display("FAIL full_cycle%0d: in_ready=%b valid=%b order=%0d want %b %b %0d", i, in_ready, out_valid, out_order, exp_ready(), mq.size() != 0, exp_head() >> RVFI_PKT_W);
      else n_pass++;
      if (i == 4) begin
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL full_drop_ready: got %b want 0", in_ready);
        else n_pass++;
      end
      if (out_valid && out_ready) got.push_back(out_order);
      step();
    end
    n_checks++;
    if (got.size() != 4 || got[0] !== 64'd0 || got[1] !== 64'd1 || got[2] !== 64'd2 || got[3] !== 64'd3)
      $display("FAIL full_drain: got %0d pops want 4 with orders 0..3", got.size());
    else n_pass++;
  endtask

  task automatic test_push_pop_full();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      in_pkt    = rand_pkt(i < 7);
      out_ready = (i >= 4);
      @(negedge clk);
      n_checks++;
      if (in_ready !== exp_ready() || out_valid !== (mq.size() != 0) || (mq.size() != 0 && {out_order, out_pkt} !== exp_head()))
        $display("FAIL pushpop_cycle%0d: in_ready=%b valid=%b order=%0d want %b %b %0d", i, in_ready, out_valid, out_order, exp_ready(), mq.size() != 0, exp_head() >> RVFI_PKT_W);
      else n_pass++;
      if (i >= 4 && i < 7) begin
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL pushpop_ready: got %b want 1", in_ready);
        else n_pass++;
      end
      if (out_valid && out_ready) got.push_back(out_order);
      step();
    end
    n_checks++;
    if (got.size() != 7) $display("FAIL pushpop_count: got %0d pops want 7", got.size());
    else n_pass++;
    for (int k = 0; k < got.size(); k++) begin
      n_checks++;
      if (got[k] !== 64'(k)) $display("FAIL pushpop_order: pop %0d got %0d want %0d", k, got[k], k);
      else n_pass++;
    end
  endtask

  task automatic test_no_commit();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_pkt    = rand_pkt(i == 10);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (i <= 10 && out_valid !== 1'b0) $display("FAIL nocommit_valid: cycle %0d got %b want 0", i, out_valid);
      else if (i == 11 && (out_valid !== 1'b1 || out_order !== 64'd0 || out_pkt !== RVFIMonPacket'(exp_head())))
        $display("FAIL nocommit_first_order: valid=%b order=%0d want 1 0", out_valid, out_order);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_pkt = rand_pkt(1'b1);
      step();
    end
    #1;
    rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL midreset: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    in_pkt = rand_pkt(1'b1);
    step();
    in_pkt = rand_pkt(1'b0);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_order !== 64'd0 || {out_order, out_pkt} !== exp_head())
      $display("FAIL midreset_restart: valid=%b order=%0d want 1 0", out_valid, out_order);
    else n_pass++;
    step();
  endtask

  task automatic test_pc_check();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_pkt = rand_pkt(i < 2);
      if (i == 0) begin in_pkt.pc_rdata = 32'h60; in_pkt.pc_wdata = 32'h64; end
      if (i == 1) begin in_pkt.pc_rdata = 32'h70; in_pkt.pc_wdata = 32'h74; end
      @(negedge clk);
      n_checks++;
      if (pc_err !== m_pc_err) $display("FAIL pc_err_cycle%0d: got %b want %b", i, pc_err, m_pc_err);
      else n_pass++;
      step();
    end
    n_checks++;
    if (pc_err !== PC_EN) $display("FAIL pc_err_sticky: got %b want %b", pc_err, PC_EN);
    else n_pass++;
    do_reset();
    @(negedge clk);
    n_checks++;
    if (pc_err !== 1'b0 || out_valid !== 1'b0) $display("FAIL pc_err_reset: pc_err=%b out_valid=%b want 0 0", pc_err, out_valid);
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    logic         prev_stall;
    RVFIMonPacket prev_pkt;
    logic [63:0]  prev_order;
    int           cycles;
    int           bad_head;
    int           bad_ready;
    int           bad_stable;
    do_reset();
    prev_stall = 1'b0;
    prev_pkt   = '0;
    prev_order = '0;
    cycles     = 0;
    bad_head   = 0;
    bad_ready  = 0;
    bad_stable = 0;
    while ((m_order < 64'd1000 || mq.size() != 0) && cycles < 20000) begin
      in_pkt    = rand_pkt((m_order < 64'd1000) && ($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready !== exp_ready()) bad_ready++;
      if (out_valid !== (mq.size() != 0) || (mq.size() != 0 && {out_order, out_pkt} !== exp_head())) bad_head++;
      if (prev_stall && (out_pkt !== prev_pkt || out_order !== prev_order)) bad_stable++;
      if (out_valid && out_ready) got.push_back(out_order);
      prev_stall = out_valid && !out_ready;
      prev_pkt   = out_pkt;
      prev_order = out_order;
      step();
      cycles++;
    end
    n_checks++;
    if (cycles >= 20000) $display("FAIL random_budget: %0d cycles, %0d orders pushed, want 1000 drained", cycles, m_order);
    else n_pass++;
    n_checks++;
    if (bad_ready != 0) $display("FAIL random_in_ready: %0d bad cycles want 0", bad_ready);
    else n_pass++;
    n_checks++;
    if (bad_head != 0) $display("FAIL random_head: %0d bad cycles want 0", bad_head);
    else n_pass++;
    n_checks++;
    if (bad_stable != 0) $display("FAIL random_stall_stable: %0d bad cycles want 0", bad_stable);
    else n_pass++;
    bad_head = 0;
    for (int k = 0; k < got.size(); k++) if (got[k] !== 64'(k)) bad_head++;
    n_checks++;
    if (got.size() != 1000 || bad_head != 0) $display("FAIL random_orders: %0d pops, %0d out of sequence, want 1000 contiguous", got.size(), bad_head);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_push_pop_full();
    test_no_commit();
    test_mid_reset();
    test_pc_check();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/rvfi_commit_queue.md
RVFI_COMMIT_QUEUE -- requirements
Module: rvfi_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered commit packets (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_pkt  input  313 (RVFIMonPacket)  packet from writeback; accepted only when in_pkt.commit=1.
REQ-005 SHALL have port in_ready  output  1  queue can accept a packet this cycle.
REQ-006 SHALL have port out_valid  output  1  out_pkt/out_order hold a valid retired instruction.
REQ-007 SHALL have port out_pkt  output  313 (RVFIMonPacket)  head packet.
REQ-008 SHALL have port out_order  output  64  retirement index of the head packet.
REQ-009 SHALL have port out_ready  input  1  monitor consumes the head packet.
REQ-010 SHALL have port pc_err  output  1  sticky PC-continuity error (RVFI_PC_CHECK_EN only; tied 0 otherwise).

Function
REQ-011 SHALL push when in_pkt.commit && in_ready; a packet with commit=0 SHALL never be stored.
REQ-012 SHALL pop when out_valid && out_ready.
REQ-013 in_ready SHALL be 1 iff occupancy < DEPTH, or occupancy = DEPTH and a pop occurs this cycle (same-cycle pop frees a slot).
REQ-014 out_valid SHALL be 1 iff occupancy > 0; no combinational bypass: a packet pushed in cycle N is visible at the output in cycle N+1 at the earliest.
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged; a push when full without a pop SHALL be dropped, with in_ready=0 during that cycle.
REQ-016 Read/write pointers SHALL wrap modulo DEPTH; occupancy SHALL be a log2(DEPTH)+1-bit counter.
REQ-017 Each pushed packet SHALL be tagged with a 64-bit order counter that starts at 0 and increments by 1 per push, wrapping at 2^64.
REQ-018 out_pkt and out_order SHALL hold stable while out_valid=1 and out_ready=0.
REQ-019 Packet fields SHALL pass through bit-exact; the block SHALL NOT modify any field.

Reset
REQ-020 On rst_n=0, occupancy, pointers and order counter SHALL clear to 0, out_valid=0, pc_err=0, and in_ready=1 from the first cycle after release.
REQ-021 Reset asserted mid-operation SHALL discard all buffered packets; storage contents need not be cleared.

Configuration
REQ-022 With RVFI_PC_CHECK_EN defined, the block SHALL hold last_pc_wdata and a have_last flag, both cleared by reset.
REQ-023 With RVFI_PC_CHECK_EN defined, on every push with have_last=1 and in_pkt.pc_rdata != last_pc_wdata, pc_err SHALL set the following cycle and remain set until reset; each push SHALL load last_pc_wdata <= in_pkt.pc_wdata and set have_last.
REQ-024 Without RVFI_PC_CHECK_EN, no check logic SHALL exist and pc_err SHALL be constant 0.

Structure
REQ-025 RVFIMonPacket and rv32i_word SHALL come from the shared rv32i_types package; a typedef rvfi_order_t (64 bits) SHALL be added there.
REQ-026 Buffering SHALL be a sub-module rvfi_fifo (parameterised width/depth, valid/ready) instantiated once; ordering and the PC check live in the top.

Verification
REQ-027 Reset then push pc_rdata=0x60, 0x64, 0x68 with out_ready=1 -> out_order 0, 1, 2 in sequence, packets bit-exact, pc_err=0.
REQ-028 DEPTH=4, out_ready=0, five commits -> in_ready=0 after the fourth, fifth dropped; drain -> exactly four packets, orders 0..3.
REQ-029 Full queue with push and pop in the same cycle -> in_ready=1, occupancy stays 4, order sequence has no gap.
REQ-030 in_pkt.commit=0 held for 10 cycles -> out_valid stays 0, order counter stays 0.
REQ-031 RVFI_PC_CHECK_EN: push pc_rdata=0x60/pc_wdata=0x64, then pc_rdata=0x70 -> pc_err=1 next cycle and sticky; rst_n pulse -> pc_err=0, out_valid=0.
REQ-032 out_ready toggled randomly for 1000 commits -> out_pkt stable while stalled, orders contiguous 0..999.
